// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator with a run-time reconfigurable timing set.
//
// Ports
//   clk_i, rst_i          single clock, synchronous active-high reset
//   cfg_valid_i           a new timing set is offered on the cfg_* inputs
//   cfg_ready_o           no accepted set is pending; an offer will be taken
//   cfg_h_*_i, cfg_v_*_i  active/front-porch/pulse/back-porch lengths (clocks / lines)
//   cfg_h_pol_i/v_pol_i   sync level driven during the pulse
//   cfg_err_o             one-cycle pulse: the previous cycle's offer was rejected
//   h_sync_o, v_sync_o    sync outputs
//   disp_ena_o            current position lies in the active area
//   col_o, row_o          active-area coordinates, zero outside the active area
//   line_start_o          position is h=0
//   frame_start_o         position is (0,0)
//
// An accepted set waits in shadow registers and is swapped in on the edge that
// leaves the last position of the frame. Every output is registered and is
// computed from the next position and the timing that will be in force there.
module vga_timing_gen #(
    parameter int unsigned H_BITS   = 10,
    parameter int unsigned V_BITS   = 9,
    parameter int unsigned H_ACTIVE = 600,
    parameter int unsigned H_FP     = 36,
    parameter int unsigned H_PULSE  = 60,
    parameter int unsigned H_BP     = 96,
    parameter int unsigned V_ACTIVE = 300,
    parameter int unsigned V_FP     = 12,
    parameter int unsigned V_PULSE  = 12,
    parameter int unsigned V_BP     = 12,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [H_BITS-1:0] cfg_h_active_i,
    input  logic [H_BITS-1:0] cfg_h_fp_i,
    input  logic [H_BITS-1:0] cfg_h_pulse_i,
    input  logic [H_BITS-1:0] cfg_h_bp_i,
    input  logic [V_BITS-1:0] cfg_v_active_i,
    input  logic [V_BITS-1:0] cfg_v_fp_i,
    input  logic [V_BITS-1:0] cfg_v_pulse_i,
    input  logic [V_BITS-1:0] cfg_v_bp_i,
    input  logic              cfg_h_pol_i,
    input  logic              cfg_v_pol_i,
    output logic              cfg_err_o,
    output logic              h_sync_o,
    output logic              v_sync_o,
    output logic              disp_ena_o,
    output logic [H_BITS-1:0] col_o,
    output logic [V_BITS-1:0] row_o,
    output logic              line_start_o,
    output logic              frame_start_o
);

    // Period sums are one bit wider than the fields.
    localparam int unsigned HW = H_BITS + 1;
    localparam int unsigned VW = V_BITS + 1;

    localparam logic [HW-1:0] HLimit = {1'b1, {H_BITS{1'b0}}};
    localparam logic [VW-1:0] VLimit = {1'b1, {V_BITS{1'b0}}};

    typedef struct packed {
        logic [H_BITS-1:0] ha;
        logic [H_BITS-1:0] hf;
        logic [H_BITS-1:0] hp;
        logic [H_BITS-1:0] hb;
        logic [V_BITS-1:0] va;
        logic [V_BITS-1:0] vf;
        logic [V_BITS-1:0] vp;
        logic [V_BITS-1:0] vb;
        logic              hpol;
        logic              vpol;
    } timing_t;

    localparam timing_t RstTiming = '{
        ha:   H_BITS'(H_ACTIVE),
        hf:   H_BITS'(H_FP),
        hp:   H_BITS'(H_PULSE),
        hb:   H_BITS'(H_BP),
        va:   V_BITS'(V_ACTIVE),
        vf:   V_BITS'(V_FP),
        vp:   V_BITS'(V_PULSE),
        vb:   V_BITS'(V_BP),
        hpol: H_POL,
        vpol: V_POL
    };

    // State
    logic [H_BITS-1:0] h_q, h_d;
    logic [V_BITS-1:0] v_q, v_d;
    logic              run_q;          // low until the first edge after reset
    timing_t           cur_q, cur_d;
    timing_t           shd_q, shd_d;
    logic              pending_q, pending_d;

    // Registered outputs
    logic              cfg_ready_q, cfg_ready_d;
    logic              cfg_err_q, cfg_err_d;
    logic              h_sync_q, h_sync_d;
    logic              v_sync_q, v_sync_d;
    logic              disp_q, disp_d;
    logic [H_BITS-1:0] col_q, col_d;
    logic [V_BITS-1:0] row_q, row_d;
    logic              line_q, line_d;
    logic              frame_q, frame_d;

    // Internal
    logic [HW-1:0] h_len, hs_start, hs_end, offer_h_sum;
    logic [VW-1:0] v_len, vs_start, vs_end, offer_v_sum;
    logic          h_last, v_last, apply, accept, offer_bad;
    timing_t       offer;

    always_comb begin
        offer = '{
            ha:   cfg_h_active_i,
            hf:   cfg_h_fp_i,
            hp:   cfg_h_pulse_i,
            hb:   cfg_h_bp_i,
            va:   cfg_v_active_i,
            vf:   cfg_v_fp_i,
            vp:   cfg_v_pulse_i,
            vb:   cfg_v_bp_i,
            hpol: cfg_h_pol_i,
            vpol: cfg_v_pol_i
        };

        // Offer validation
        offer_h_sum = HW'(offer.ha) + HW'(offer.hf) + HW'(offer.hp) + HW'(offer.hb);
        offer_v_sum = VW'(offer.va) + VW'(offer.vf) + VW'(offer.vp) + VW'(offer.vb);
        offer_bad   = (offer.ha == '0) || (offer.hp == '0) ||
                      (offer.va == '0) || (offer.vp == '0) ||
                      (offer_h_sum > HLimit) || (offer_v_sum > VLimit);
        accept      = cfg_valid_i && cfg_ready_q;

        // Position advance under the timing currently in force
        h_len  = HW'(cur_q.ha) + HW'(cur_q.hf) + HW'(cur_q.hp) + HW'(cur_q.hb);
        v_len  = VW'(cur_q.va) + VW'(cur_q.vf) + VW'(cur_q.vp) + VW'(cur_q.vb);
        h_last = (HW'(h_q) == h_len - HW'(1));
        v_last = (VW'(v_q) == v_len - VW'(1));
        apply  = run_q && h_last && v_last && pending_q;

        h_d = h_q;
        v_d = v_q;
        if (!run_q) begin
            h_d = '0;
            v_d = '0;
        end else if (h_last) begin
            h_d = '0;
            v_d = v_last ? '0 : v_q + V_BITS'(1);
        end else begin
            h_d = h_q + H_BITS'(1);
        end

        // Timing set swap and handshake
        cur_d     = apply ? shd_q : cur_q;
        shd_d     = shd_q;
        pending_d = pending_q;
        if (apply) begin
            pending_d = 1'b0;
        end else if (accept && !offer_bad) begin
            shd_d     = offer;
            pending_d = 1'b1;
        end
        cfg_ready_d = !pending_d;
        cfg_err_d   = accept && offer_bad;

        // Outputs describe (h_d, v_d) under cur_d
        hs_start = HW'(cur_d.ha) + HW'(cur_d.hf);
        hs_end   = hs_start + HW'(cur_d.hp);
        vs_start = VW'(cur_d.va) + VW'(cur_d.vf);
        vs_end   = vs_start + VW'(cur_d.vp);

        disp_d   = (h_d < cur_d.ha) && (v_d < cur_d.va);
        col_d    = disp_d ? h_d : '0;
        row_d    = disp_d ? v_d : '0;
        h_sync_d = ((HW'(h_d) >= hs_start) && (HW'(h_d) < hs_end)) ? cur_d.hpol : ~cur_d.hpol;
        v_sync_d = ((VW'(v_d) >= vs_start) && (VW'(v_d) < vs_end)) ? cur_d.vpol : ~cur_d.vpol;
        line_d   = (h_d == '0);
        frame_d  = (h_d == '0) && (v_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_q         <= '0;
            v_q         <= '0;
            run_q       <= 1'b0;
            cur_q       <= RstTiming;
            shd_q       <= RstTiming;
            pending_q   <= 1'b0;
            cfg_ready_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            h_sync_q    <= ~H_POL;
            v_sync_q    <= ~V_POL;
            disp_q      <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            line_q      <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            run_q       <= 1'b1;
            cur_q       <= cur_d;
            shd_q       <= shd_d;
            pending_q   <= pending_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
            h_sync_q    <= h_sync_d;
            v_sync_q    <= v_sync_d;
            disp_q      <= disp_d;
            col_q       <= col_d;
            row_q       <= row_d;
            line_q      <= line_d;
            frame_q     <= frame_d;
        end
    end

    assign cfg_ready_o   = cfg_ready_q;
    assign cfg_err_o     = cfg_err_q;
    assign h_sync_o      = h_sync_q;
    assign v_sync_o      = v_sync_q;
    assign disp_ena_o    = disp_q;
    assign col_o         = col_q;
    assign row_o         = row_q;
    assign line_start_o  = line_q;
    assign frame_start_o = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. A small reference model tracks the elapsed cycle
// count within the frame and derives (h,v) by division, plus the handshake state.
module tb_vga_timing_gen;

    localparam int HB = 6;
    localparam int VB = 5;

    typedef struct {
        int ha, hf, hp, hb;
        int va, vf, vp, vb;
        int hpol, vpol;
    } tim_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, cfg_valid;
    logic [HB-1:0] ch_a, ch_f, ch_p, ch_b;
    logic [VB-1:0] cv_a, cv_f, cv_p, cv_b;
    logic          ch_pol, cv_pol;
    logic          cfg_ready, cfg_err, h_sync, v_sync, disp_ena, line_start, frame_start;
    logic [HB-1:0] col;
    logic [VB-1:0] row;

    vga_timing_gen #(
        .H_BITS(HB), .V_BITS(VB),
        .H_ACTIVE(4), .H_FP(1), .H_PULSE(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_PULSE(1), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_h_active_i(ch_a), .cfg_h_fp_i(ch_f), .cfg_h_pulse_i(ch_p), .cfg_h_bp_i(ch_b),
        .cfg_v_active_i(cv_a), .cfg_v_fp_i(cv_f), .cfg_v_pulse_i(cv_p), .cfg_v_bp_i(cv_b),
        .cfg_h_pol_i(ch_pol), .cfg_v_pol_i(cv_pol),
        .cfg_err_o(cfg_err), .h_sync_o(h_sync), .v_sync_o(v_sync), .disp_ena_o(disp_ena),
        .col_o(col), .row_o(row), .line_start_o(line_start), .frame_start_o(frame_start)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    tim_t dflt, cur, shd, drv;
    int   t;
    bit   m_started, m_pending, m_ready, m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int hper(input tim_t x);
        return x.ha + x.hf + x.hp + x.hb;
    endfunction

    function automatic int vper(input tim_t x);
        return x.va + x.vf + x.vp + x.vb;
    endfunction

    function automatic bit rejected(input tim_t x);
        return x.ha == 0 || x.hp == 0 || x.va == 0 || x.vp == 0 ||
               hper(x) > (1 << HB) || vper(x) > (1 << VB);
    endfunction

    function automatic tim_t mk(input int ha, hf, hp, hb, va, vf, vp, vb, hpol, vpol);
        tim_t x;
        x.ha = ha; x.hf = hf; x.hp = hp; x.hb = hb;
        x.va = va; x.vf = vf; x.vp = vp; x.vb = vb;
        x.hpol = hpol; x.vpol = vpol;
        return x;
    endfunction

    task automatic set_offer(input tim_t x);
        drv    = x;
        ch_a   = HB'(x.ha); ch_f = HB'(x.hf); ch_p = HB'(x.hp); ch_b = HB'(x.hb);
        cv_a   = VB'(x.va); cv_f = VB'(x.vf); cv_p = VB'(x.vp); cv_b = VB'(x.vb);
        ch_pol = x.hpol[0];
        cv_pol = x.vpol[0];
    endtask

    task automatic check_outputs();
        int h, v, hpw, vpw, e_disp, hs0, vs0;
        if (!m_started) begin
            check("rst_ready", cfg_ready, 0);
            check("rst_err", cfg_err, 0);
            check("rst_hsync", h_sync, 1);
            check("rst_vsync", v_sync, 0);
            check("rst_disp", disp_ena, 0);
            check("rst_col", col, 0);
            check("rst_row", row, 0);
            check("rst_ls", line_start, 0);
            check("rst_fs", frame_start, 0);
        end else begin
            hpw    = hper(cur);
            vpw    = vper(cur);
            h      = t % hpw;
            v      = t / hpw;
            e_disp = (h < cur.ha && v < cur.va) ? 1 : 0;
            hs0    = cur.ha + cur.hf;
            vs0    = cur.va + cur.vf;
            check("ready", cfg_ready, m_ready);
            check("err", cfg_err, m_err);
            check("disp", disp_ena, e_disp);
            check("col", col, e_disp ? h : 0);
            check("row", row, e_disp ? v : 0);
            check("hsync", h_sync, (h >= hs0 && h < hs0 + cur.hp) ? cur.hpol : 1 - cur.hpol);
            check("vsync", v_sync, (v >= vs0 && v < vs0 + cur.vp) ? cur.vpol : 1 - cur.vpol);
            check("ls", line_start, h == 0);
            check("fs", frame_start, t == 0);
        end
    endtask

    task automatic model_update();
        bit acc, newpend;
        if (rst) begin
            m_started = 0; m_pending = 0; m_ready = 0; m_err = 0;
            cur = dflt;
        end else if (!m_started) begin
            m_started = 1; t = 0; m_ready = 1; m_err = 0;
        end else begin
            acc     = cfg_valid && m_ready;
            m_err   = acc && rejected(drv);
            newpend = m_pending;
            if (t == hper(cur) * vper(cur) - 1) begin
                t = 0;
                if (m_pending) begin
                    cur     = shd;
                    newpend = 0;
                end
            end else begin
                t++;
            end
            if (acc && !rejected(drv)) begin
                shd     = drv;
                newpend = 1;
            end
            m_pending = newpend;
            m_ready   = !newpend;
        end
    endtask

    task automatic step();
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        cfg_valid = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int target);
        bit found = 0;
        cfg_valid = 0;
        for (int i = 0; i < 5000; i++) begin
            if (m_started && t == target) begin
                found = 1;
                break;
            end
            step();
        end
        if (!found) check("run_to_timeout", 0, 1);
    endtask

    task automatic offer_once(input tim_t x);
        set_offer(x);
        cfg_valid = 1;
        step();
        cfg_valid = 0;
    endtask

    task automatic do_reset(input int n);
        rst       = 1;
        cfg_valid = 0;
        for (int i = 0; i < n; i++) step();
        rst = 0;
        step();
    endtask

    function automatic tim_t rand_tim();
        tim_t x;
        case ($urandom % 8)
            0: x = mk($urandom_range(1, 6), $urandom_range(0, 2), 0, $urandom_range(0, 2),
                      $urandom_range(1, 4), 1, 1, 1, $urandom % 2, $urandom % 2);
            1: x = mk($urandom_range(1, 6), 1, 1, 1, 0, $urandom_range(0, 2),
                      $urandom_range(1, 2), 1, $urandom % 2, $urandom % 2);
            2: x = mk($urandom_range(10, 31), $urandom_range(0, 31), $urandom_range(1, 31),
                      $urandom_range(0, 31), $urandom_range(1, 2), 0, 1, 0,
                      $urandom % 2, $urandom % 2);
            3: x = mk($urandom_range(1, 4), 1, 1, 1, $urandom_range(4, 15),
                      $urandom_range(0, 15), $urandom_range(1, 15), $urandom_range(0, 15),
                      $urandom % 2, $urandom % 2);
            default: x = mk($urandom_range(1, 6), $urandom_range(0, 2), $urandom_range(1, 3),
                            $urandom_range(0, 2), $urandom_range(1, 4), $urandom_range(0, 2),
                            $urandom_range(1, 2), $urandom_range(0, 2),
                            $urandom % 2, $urandom % 2);
        endcase
        return x;
    endfunction

    initial begin
        int n_disp, n_hlow, n_vhigh, n_fs, n_hhigh;
        dflt = mk(4, 1, 2, 1, 3, 1, 1, 1, 0, 1);
        cur  = dflt;
        shd  = dflt;
        m_started = 0; m_pending = 0; m_ready = 0; m_err = 0; t = 0;
        set_offer(dflt);
        rst       = 1;
        cfg_valid = 0;
        @(posedge clk);
        #1;

        // Default timing, one full frame from reset release
        do_reset(3);
        n_disp = 0; n_hlow = 0; n_vhigh = 0; n_fs = 0;
        for (int i = 0; i < 48; i++) begin
            n_disp  += int'(disp_ena);
            n_hlow  += int'(!h_sync);
            n_fs    += int'(frame_start);
            if (t % 8 == 5) n_vhigh += int'(v_sync);
            step();
        end
        check("frame_disp_cnt", n_disp, 12);
        check("frame_hlow_cnt", n_hlow, 12);
        check("frame_vhigh_at_h5", n_vhigh, 1);
        check("frame_fs_cnt", n_fs, 1);
        check("frame_wrap_fs", frame_start, 1);

        // col/row trace around the right edge of the active area
        run_to(2 * 8 + 3);
        check("col_3_2", col, 3);
        check("row_3_2", row, 2);
        step();
        check("col_4_2", col, 0);
        check("disp_4_2", disp_ena, 0);

        // Mid-frame reconfiguration, then an ignored bad offer while pending
        run_to(8);
        offer_once(mk(2, 1, 1, 1, 3, 1, 1, 1, 0, 1));
        check("pending_ready", cfg_ready, 0);
        offer_once(mk(2, 1, 0, 1, 3, 1, 1, 1, 0, 1));
        check("ignored_err", cfg_err, 0);
        run_to(0);
        check("applied_fs", frame_start, 1);
        check("applied_ready", cfg_ready, 1);
        run(5);
        check("hp5_ls", line_start, 1);
        run(30);

        // Rejects and the exact-limit horizontal period
        offer_once(mk(2, 1, 0, 1, 3, 1, 1, 1, 0, 1));
        check("rej_pulse_err", cfg_err, 1);
        check("rej_pulse_ready", cfg_ready, 1);
        step();
        check("rej_pulse_err_gone", cfg_err, 0);
        offer_once(mk(60, 2, 2, 1, 3, 1, 1, 1, 0, 1));
        check("rej_hsum_err", cfg_err, 1);
        offer_once(mk(2, 1, 1, 1, 30, 1, 1, 1, 0, 1));
        check("rej_vsum_err", cfg_err, 1);
        run(7);
        offer_once(mk(60, 1, 2, 1, 3, 1, 1, 1, 0, 1));
        check("limit_accept_err", cfg_err, 0);
        check("limit_accept_ready", cfg_ready, 0);
        run_to(0);
        run(64 * 6);

        // Reset while a set is pending at (6,3)
        do_reset(2);
        run_to(10);
        offer_once(mk(2, 1, 1, 1, 3, 1, 1, 1, 0, 1));
        run_to(3 * 8 + 6);
        rst = 1;
        step();
        step();
        rst = 0;
        step();
        run(100);

        // Polarity swap
        run_to(5);
        offer_once(mk(4, 1, 2, 1, 3, 1, 1, 1, 1, 0));
        run_to(0);
        n_hhigh = 0;
        for (int i = 0; i < 48; i++) begin
            n_hhigh += int'(h_sync);
            step();
        end
        check("swap_hhigh_cnt", n_hhigh, 12);

        // Random traffic with occasional resets
        for (int i = 0; i < 2500; i++) begin
            rst = ($urandom % 400 == 0);
            set_offer(rand_tim());
            cfg_valid = !rst && ($urandom % 6 == 0);
            step();
        end
        rst       = 0;
        cfg_valid = 0;
        run(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
